// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the fetch FSM state enum, the reset/NOP constants, the PC step,
// the captured {pc, instr} pair type and a PC alignment helper.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'h0000_0004;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pair_t;

    // Instructions are word aligned; the low two bits of a target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// I-cache request/response bus between the fetch stage and the I-cache.
// master: fetch side (drives request valid/address, receives ready and response)
// slave : I-cache side
interface if_stage_if;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_ready, icache_resp_valid, icache_resp_data
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_ready, icache_resp_valid, icache_resp_data
    );
endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, instr} pair while decode stalls.
// Ports: clk/reset; load (write pair), clear (flush), read (entry handed to
// IF/ID); load_pc/load_instr in; valid/pc/instr out.
// Priority: clear > load > read.
module if_skid_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        read,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    // Skid entry storage with async reset to empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (read) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one I-cache request at a time for pc_addr,
// captures the response into the IF/ID register (or a skid entry when decode
// stalls) and tells the external PC register what to load.
// Ports: clk, reset (async, active high); pc_addr in; next_pc/pc_halt out;
// icache bus (master modport); redirect_valid/redirect_pc in; id_stall in;
// ifid_valid/ifid_pc/ifid_instr out (registered).
module if_stage
    import if_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_addr,
    output logic [31:0]       next_pc,
    output logic              pc_halt,
    if_stage_if.master        icache,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_stall,
    output logic              ifid_valid,
    output logic [31:0]       ifid_pc,
    output logic [31:0]       ifid_instr
);

    if_state_e   state_r, state_nxt_s;
    logic        req_valid_s;
    logic        accept_s;
    logic        capture_s;
    logic        ifid_free_s;
    logic        skid_load_s, skid_read_s;
    logic        skid_valid_s;
    logic [31:0] skid_pc_s, skid_instr_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and request generation.
    always_comb begin
        state_nxt_s = state_r;
        req_valid_s = 1'b0;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            FETCH: begin
                // No new request while a skid entry is still waiting.
                req_valid_s = !skid_valid_s;
                accept_s    = req_valid_s && icache.icache_req_ready;
                if (accept_s) begin
                    state_nxt_s = redirect_valid ? DRAIN : WAIT;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            WAIT: begin
                capture_s = icache.icache_resp_valid && !redirect_valid;
                if (icache.icache_resp_valid) begin
                    state_nxt_s = FETCH;
                end else if (redirect_valid) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DRAIN: begin
                // The stale response is swallowed; once it lands the bus is free.
                if (icache.icache_resp_valid) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = FETCH;
            end
        endcase
    end

    assign icache.icache_req_valid = req_valid_s && !reset;
    assign icache.icache_req_addr  = pc_addr;

    // PC update: redirect wins, a captured response advances by one word.
    always_comb begin
        if (reset) begin
            next_pc = RESET_PC;
            pc_halt = 1'b1;
        end else if (redirect_valid) begin
            next_pc = align_pc(redirect_pc);
            pc_halt = 1'b0;
        end else if (capture_s) begin
            next_pc = pc_addr + PC_STEP;
            pc_halt = 1'b0;
        end else begin
            next_pc = pc_addr;
            pc_halt = 1'b1;
        end
    end

    // IF/ID can take a new pair when empty or being consumed this cycle.
    assign ifid_free_s = !ifid_valid || !id_stall;
    assign skid_read_s = !redirect_valid && ifid_free_s && skid_valid_s;
    assign skid_load_s = capture_s && (!ifid_free_s || skid_valid_s);

    if_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load_s),
        .clear      (redirect_valid),
        .read       (skid_read_s),
        .load_pc    (pc_addr),
        .load_instr (icache.icache_resp_data),
        .valid      (skid_valid_s),
        .pc         (skid_pc_s),
        .instr      (skid_instr_s)
    );

    // IF/ID register: skid entry refills before a same-cycle response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= RESET_PC;
            ifid_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            ifid_valid <= 1'b0;
        end else if (ifid_free_s) begin
            if (skid_valid_s) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= skid_pc_s;
                ifid_instr <= skid_instr_s;
            end else if (capture_s) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= pc_addr;
                ifid_instr <= icache.icache_resp_data;
            end else begin
                ifid_valid <= 1'b0;
            end
        end else begin
            ifid_valid <= ifid_valid;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The bench owns the PC register and plays the
// I-cache; every response expected to reach IF/ID is pushed to a scoreboard
// queue and popped when IF/ID is checked.
module tb_if_stage;
    import if_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc_r;
    logic [31:0] next_pc;
    logic        pc_halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    if_stage_if icache ();

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .pc_addr        (pc_r),
        .next_pc        (next_pc),
        .pc_halt        (pc_halt),
        .icache         (icache),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register driven by the stage's next_pc/pc_halt.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_r <= 32'h0000_0000;
        else if (!pc_halt) pc_r <= next_pc;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    // Pop the oldest expected pair and compare it with IF/ID.
    task automatic expect_ifid(input string tag);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
            chk({tag, "_pc"}, ifid_pc, e[63:32]);
            chk({tag, "_instr"}, ifid_instr, e[31:0]);
        end
    endtask

    task automatic drive_resp(input logic [31:0] data, input logic keep);
        icache.icache_resp_valid = 1'b1;
        icache.icache_resp_data  = data;
        if (keep) sb_q.push_back({pc_r, data});
    endtask

    task automatic nxt();
        @(negedge clk);
        icache.icache_resp_valid = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        id_stall = 1'b0;
        icache.icache_req_ready = 1'b1;
        icache.icache_resp_valid = 1'b0;
        icache.icache_resp_data = 32'd0;
        #2;
        chk("rst_req_valid", {31'd0, icache.icache_req_valid}, 32'd0);
        chk("rst_pc_halt", {31'd0, pc_halt}, 32'd1);
        chk("rst_next_pc", next_pc, 32'h0000_0000);
        chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_ifid_pc", ifid_pc, 32'h0000_0000);
        chk("rst_ifid_instr", ifid_instr, 32'h0000_0013);

        // Basic fetch of pc 0.
        @(negedge clk); reset = 1'b0; #1;
        chk("f0_req_valid", {31'd0, icache.icache_req_valid}, 32'd1);
        chk("f0_req_addr", icache.icache_req_addr, 32'h0000_0000);
        nxt(); drive_resp(32'h0050_0093, 1'b1); #1;
        chk("f0_req_idle_wait", {31'd0, icache.icache_req_valid}, 32'd0);
        chk("f0_next_pc", next_pc, 32'h0000_0004);
        chk("f0_pc_halt", {31'd0, pc_halt}, 32'd0);
        nxt(); #1;
        expect_ifid("f0_ifid");
        chk("f1_req_addr", icache.icache_req_addr, 32'h0000_0004);
        chk("f1_req_valid", {31'd0, icache.icache_req_valid}, 32'd1);

        // Decode stall: response for pc 4 parks in the skid buffer.
        id_stall = 1'b1;
        nxt(); drive_resp(32'h0010_0113, 1'b1); #1;
        chk("st_next_pc", next_pc, 32'h0000_0008);
        nxt(); #1;
        chk("st_ifid_hold1", ifid_pc, 32'h0000_0000);
        chk("st_no_req1", {31'd0, icache.icache_req_valid}, 32'd0);
        nxt(); #1;
        chk("st_ifid_hold2", ifid_instr, 32'h0050_0093);
        chk("st_no_req2", {31'd0, icache.icache_req_valid}, 32'd0);
        id_stall = 1'b0;
        nxt(); #1;
        expect_ifid("st_skid");
        chk("st_req_addr", icache.icache_req_addr, 32'h0000_0008);

        // Redirect while waiting: DRAIN, late response discarded.
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        icache.icache_req_ready = 1'b0; #1;
        chk("rd_next_pc", next_pc, 32'h0000_0100);
        chk("rd_pc_halt", {31'd0, pc_halt}, 32'd0);
        nxt(); #1;
        chk("rd_ifid_flush", {31'd0, ifid_valid}, 32'd0);
        chk("rd_drain_no_req", {31'd0, icache.icache_req_valid}, 32'd0);
        nxt(); drive_resp(32'hDEAD_BEEF, 1'b0); #1;
        chk("rd_late_halt", {31'd0, pc_halt}, 32'd1);
        icache.icache_req_ready = 1'b1;
        nxt(); #1;
        chk("rd_late_ifid", {31'd0, ifid_valid}, 32'd0);
        chk("rd_req_valid", {31'd0, icache.icache_req_valid}, 32'd1);
        chk("rd_req_addr", icache.icache_req_addr, 32'h0000_0100);

        // Redirect coincident with response: dropped, straight to FETCH.
        nxt(); drive_resp(32'h1111_1111, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
        chk("rc_next_pc", next_pc, 32'h0000_0200);
        nxt(); #1;
        chk("rc_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rc_req_valid", {31'd0, icache.icache_req_valid}, 32'd1);
        chk("rc_req_addr", icache.icache_req_addr, 32'h0000_0200);
        nxt(); drive_resp(32'h2222_2222, 1'b1); #1;
        chk("rc_next_pc2", next_pc, 32'h0000_0204);
        nxt(); #1;
        expect_ifid("rc_ifid");

        // Wrap: fetch at 0xFFFFFFFC.
        icache.icache_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        chk("wr_next_pc_align", next_pc, 32'hFFFF_FFFC);
        nxt(); icache.icache_req_ready = 1'b1; #1;
        chk("wr_req_addr", icache.icache_req_addr, 32'hFFFF_FFFC);
        nxt(); drive_resp(32'h3333_3333, 1'b1); #1;
        chk("wr_next_pc", next_pc, 32'h0000_0000);
        nxt(); #1;
        expect_ifid("wr_ifid");
        chk("wr_req_addr0", icache.icache_req_addr, 32'h0000_0000);
        id_stall = 1'b1;

        // Async reset mid-cycle while waiting on pc 0.
        nxt(); #2;
        reset = 1'b1; #1;
        chk("ar_ifid_valid", {31'd0, ifid_valid}, 32'd0);
        chk("ar_ifid_instr", ifid_instr, 32'h0000_0013);
        chk("ar_req_valid", {31'd0, icache.icache_req_valid}, 32'd0);
        chk("ar_pc_halt", {31'd0, pc_halt}, 32'd1);
        nxt(); reset = 1'b0; id_stall = 1'b0;
        icache.icache_req_ready = 1'b0;
        drive_resp(32'h5555_5555, 1'b0); #1;
        chk("ar_stray_halt", {31'd0, pc_halt}, 32'd1);
        chk("ar_req_addr", icache.icache_req_addr, 32'h0000_0000);
        nxt(); icache.icache_req_ready = 1'b1; #1;
        chk("ar_stray_ifid", {31'd0, ifid_valid}, 32'd0);
        nxt(); drive_resp(32'h4444_4444, 1'b1); #1;
        chk("ar_next_pc", next_pc, 32'h0000_0004);
        nxt(); #1;
        expect_ifid("ar_ifid");
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
